// File: rtl/pt_pkg.sv
// ----------------------------------------------------------------------------
// pt_pkg -- shared pipeline package.
//
// Purpose : default sample width / ring depth and the IDLE/FILL/RUN history
//           state encoding shared by the pipeline tap blocks.
// Contents:
//   PT_DATA_WIDTH  default sample width (signed samples)
//   PT_DEPTH       default ring-buffer depth (power of two, >= 2)
//   pt_state_e     history state: IDLE (empty), FILL (partial), RUN (full)
//   pt_sat_inc     saturating increment used by history counters
// ----------------------------------------------------------------------------
package pt_pkg;

    localparam int unsigned PT_DATA_WIDTH = 16;
    localparam int unsigned PT_DEPTH      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } pt_state_e;

    // Saturating increment of a 32-bit count against a limit; callers
    // truncate the result back to their counter width.
    function automatic logic [31:0] pt_sat_inc(input logic [31:0] cnt,
                                               input logic [31:0] limit);
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/tdr_ring_ram.sv
// ----------------------------------------------------------------------------
// tdr_ring_ram -- ring-buffer storage for tap_delay_reader.
//
// Purpose : DEPTH x DATA_WIDTH memory with one write port and one registered
//           read port. A read and a write to the same address on the same
//           edge return the old contents (read-before-write).
// Ports   :
//   clk    in   clock, rising edge
//   rstn   in   asynchronous active-low reset (read register only; the
//               array itself is never reset)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data (signed)
//   re     in   read-register load enable
//   rzero  in   when loading, load zero instead of the array contents
//   raddr  in   read address
//   rdata  out  registered read data (signed)
// ----------------------------------------------------------------------------
module tdr_ring_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic                         rzero,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem above guarantees the old word is seen here
    // when raddr == waddr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/tap_delay_reader.sv
// ----------------------------------------------------------------------------
// tap_delay_reader -- programmable tap delay line over a ring buffer.
//
// Purpose : each accepted sample (en=1, clr=0) is written into the ring and,
//           on the same edge, the sample accepted D en-cycles earlier is
//           registered for output. yvalid flags that enough history exists
//           for the requested delay.
// Ports   :
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   en      in   sample strobe; outputs are forced to zero while low
//   clr     in   synchronous history clear (wins over en)
//   xin     in   incoming sample (signed, DATA_WIDTH)
//   delay   in   requested tap delay D in en-cycles ($clog2(DEPTH)+1 bits)
//   yout    out  delayed sample (signed, DATA_WIDTH)
//   yvalid  out  yout holds genuine history
// Config  :
//   TDR_DELAY_CLAMP_EN  when defined, delay 0 is used as 1 and delay > DEPTH
//                       as DEPTH; otherwise such delays yield yvalid=0, yout=0.
// ----------------------------------------------------------------------------
module tap_delay_reader
    import pt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PT_DATA_WIDTH,
    parameter int unsigned DEPTH      = PT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          clr,
    input  logic signed [DATA_WIDTH-1:0]  xin,
    input  logic [$clog2(DEPTH):0]        delay,
    output logic signed [DATA_WIDTH-1:0]  yout,
    output logic                          yvalid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]                wptr;
    logic [CW-1:0]                fill_cnt;
    pt_state_e                    state;
    logic                         valid_q;
    logic signed [DATA_WIDTH-1:0] yout_q;

    logic [CW-1:0] d_eff;
    logic          d_ok;
    logic [AW-1:0] raddr;
    logic          accept;

    // ---------------------------------------------------------------------
    // Effective delay
    // ---------------------------------------------------------------------
    always_comb begin
        d_eff = delay;
        d_ok  = 1'b1;
`ifdef TDR_DELAY_CLAMP_EN
        if (delay == '0) begin
            d_eff = CW'(1);
        end else if (delay > FULL) begin
            d_eff = FULL;
        end
`else
        if ((delay == '0) || (delay > FULL)) begin
            d_ok = 1'b0;
        end
`endif
    end

    // D == DEPTH wraps to wptr itself; the RAM's read-before-write then
    // yields the sample being overwritten, i.e. the one DEPTH cycles old.
    assign raddr  = wptr - d_eff[AW-1:0];
    assign accept = en & ~clr;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    tdr_ring_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (accept),
        .waddr (wptr),
        .wdata (xin),
        .re    (en | clr),
        .rzero (clr | ~d_ok),
        .raddr (raddr),
        .rdata (yout_q)
    );

    // ---------------------------------------------------------------------
    // Pointer, fill counter, validity and history state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            fill_cnt <= '0;
            valid_q  <= 1'b0;
            state    <= IDLE;
        end else if (clr) begin
            wptr     <= '0;
            fill_cnt <= '0;
            valid_q  <= 1'b0;
            state    <= IDLE;
        end else if (en) begin
            wptr     <= wptr + 1'b1;
            fill_cnt <= CW'(pt_sat_inc(32'(fill_cnt), 32'(DEPTH)));
            // Compared against the pre-increment count: the sample being
            // written this edge is not yet history.
            valid_q  <= d_ok && (fill_cnt >= d_eff);
            unique case (state)
                IDLE: state <= (FULL == CW'(1)) ? RUN : FILL;
                FILL: state <= (fill_cnt == FULL - 1'b1) ? RUN : FILL;
                RUN:  state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs gated by the strobe
    // ---------------------------------------------------------------------
    assign yout   = en ? yout_q : '0;
    assign yvalid = en & valid_q;

endmodule

// File: tb/tb_tap_delay_reader.sv
module tb_tap_delay_reader;
    import pt_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic                 clk;
    logic                 rstn;
    logic                 en;
    logic                 clr;
    logic signed [DW-1:0] xin;
    logic [3:0]           delay;
    logic signed [DW-1:0] yout;
    logic                 yvalid;

    int pass_cnt;
    int total_cnt;

    tap_delay_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .clr    (clr),
        .xin    (xin),
        .delay  (delay),
        .yout   (yout),
        .yvalid (yvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // Drive one accepted sample and return 1 time unit after the edge.
    task automatic push(input logic signed [DW-1:0] x);
        xin = x;
        en  = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        en  = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        xin   = 16'sd5;
        delay = 4'd3;
        #12;
        total_cnt++;
        if (yout !== 16'sd0) $display("FAIL reset_yout: got %0d required 0", yout);
        else pass_cnt++;
        total_cnt++;
        if (yvalid !== 1'b0) $display("FAIL reset_yvalid: got %0b required 0", yvalid);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE) $display("FAIL reset_state: got %0d required %0d", dut.state, IDLE);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (yvalid !== 1'b0 || yout !== 16'sd0)
            $display("FAIL reset_held: got yvalid=%0b yout=%0d required 0/0", yvalid, yout);
        else pass_cnt++;
        rstn = 1'b1;
        en   = 1'b0;
    endtask

    task automatic test_delay3();
        do_clr();
        delay = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            push(16'(k));
            total_cnt++;
            if (yvalid !== (k >= 4))
                $display("FAIL d3_yvalid[%0d]: got %0b required %0b", k, yvalid, (k >= 4));
            else pass_cnt++;
            if (k >= 4) begin
                total_cnt++;
                if (yout !== 16'(k - 3))
                    $display("FAIL d3_yout[%0d]: got %0d required %0d", k, yout, k - 3);
                else pass_cnt++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_full_depth();
        do_clr();
        delay = 4'd8;
        for (int k = 1; k <= 10; k++) begin
            push(16'(9 + k));
            total_cnt++;
            if (yvalid !== (k >= 9))
                $display("FAIL d8_yvalid[%0d]: got %0b required %0b", k, yvalid, (k >= 9));
            else pass_cnt++;
            if (k >= 9) begin
                total_cnt++;
                if (yout !== 16'(k + 1))
                    $display("FAIL d8_yout[%0d]: got %0d required %0d", k, yout, k + 1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dut.state !== RUN) $display("FAIL d8_state: got %0d required %0d", dut.state, RUN);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_gap();
        do_clr();
        delay = 4'd3;
        for (int k = 1; k <= 5; k++) push(16'(k));
        total_cnt++;
        if (yout !== 16'sd2 || yvalid !== 1'b1)
            $display("FAIL gap_pre: got yout=%0d yvalid=%0b required 2/1", yout, yvalid);
        else pass_cnt++;
        en  = 1'b0;
        xin = 16'sd77;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (yout !== 16'sd0 || yvalid !== 1'b0)
                $display("FAIL gap_idle[%0d]: got yout=%0d yvalid=%0b required 0/0", c, yout, yvalid);
            else pass_cnt++;
        end
        for (int k = 6; k <= 8; k++) begin
            push(16'(k));
            total_cnt++;
            if (yout !== 16'(k - 3) || yvalid !== 1'b1)
                $display("FAIL gap_resume[%0d]: got yout=%0d yvalid=%0b required %0d/1", k, yout, yvalid, k - 3);
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

    task automatic test_clr();
        do_clr();
        delay = 4'd3;
        for (int k = 1; k <= 6; k++) push(16'(k));
        xin = 16'sd99;
        en  = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (yout !== 16'sd0 || yvalid !== 1'b0)
            $display("FAIL clr_out: got yout=%0d yvalid=%0b required 0/0", yout, yvalid);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE) $display("FAIL clr_state: got %0d required %0d", dut.state, IDLE);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            push(16'(20 + k));
            total_cnt++;
            if (yvalid !== (k >= 4))
                $display("FAIL clr_refill_yvalid[%0d]: got %0b required %0b", k, yvalid, (k >= 4));
            else pass_cnt++;
        end
        total_cnt++;
        if (yout !== 16'sd21) $display("FAIL clr_refill_yout: got %0d required 21", yout);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_clr();
        delay = 4'd3;
        for (int k = 1; k <= 10; k++) push(16'(k));
        total_cnt++;
        if (dut.state !== RUN || yvalid !== 1'b1)
            $display("FAIL rst_mid_pre: got state=%0d yvalid=%0b required %0d/1", dut.state, yvalid, RUN);
        else pass_cnt++;
        #3;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (yout !== 16'sd0 || yvalid !== 1'b0)
            $display("FAIL rst_mid_now: got yout=%0d yvalid=%0b required 0/0", yout, yvalid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        delay = 4'd2;
        for (int k = 1; k <= 3; k++) begin
            push(16'(30 + k));
            total_cnt++;
            if (yvalid !== (k >= 3))
                $display("FAIL rst_refill_yvalid[%0d]: got %0b required %0b", k, yvalid, (k >= 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (yout !== 16'sd31) $display("FAIL rst_refill_yout: got %0d required 31", yout);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_bad_delay();
        logic signed [DW-1:0] e_y0;
        logic signed [DW-1:0] e_y9;
        logic                 e_v;
`ifdef TDR_DELAY_CLAMP_EN
        e_y0 = 16'sd10;
        e_y9 = 16'sd4;
        e_v  = 1'b1;
`else
        e_y0 = 16'sd0;
        e_y9 = 16'sd0;
        e_v  = 1'b0;
`endif
        do_clr();
        delay = 4'd3;
        for (int k = 1; k <= 10; k++) push(16'(k));
        delay = 4'd0;
        push(16'sd11);
        total_cnt++;
        if (yout !== e_y0 || yvalid !== e_v)
            $display("FAIL delay0: got yout=%0d yvalid=%0b required %0d/%0b", yout, yvalid, e_y0, e_v);
        else pass_cnt++;
        delay = 4'd9;
        push(16'sd12);
        total_cnt++;
        if (yout !== e_y9 || yvalid !== e_v)
            $display("FAIL delay9: got yout=%0d yvalid=%0b required %0d/%0b", yout, yvalid, e_y9, e_v);
        else pass_cnt++;
        delay = 4'd3;
        push(16'sd13);
        total_cnt++;
        if (yout !== 16'sd10 || yvalid !== 1'b1)
            $display("FAIL delay_restore: got yout=%0d yvalid=%0b required 10/1", yout, yvalid);
        else pass_cnt++;
        en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_delay3();
        test_full_depth();
        test_gap();
        test_clr();
        test_reset_mid();
        test_bad_delay();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tap_delay_reader.md
TAP_DELAY_READER -- requirements
Module: tap_delay_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed).
REQ-002 SHALL have parameter DEPTH, default 32, ring-buffer entries, power of two, >=2.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1, sample strobe; one sample accepted per cycle with en=1.
REQ-006 SHALL have port clr, input, 1, synchronous history clear.
REQ-007 SHALL have port xin, input, DATA_WIDTH signed, incoming sample.
REQ-008 SHALL have port delay, input, $clog2(DEPTH)+1 unsigned, requested tap delay D in en-cycles.
REQ-009 SHALL have port yout, output, DATA_WIDTH signed, delayed sample.
REQ-010 SHALL have port yvalid, output, 1, yout holds genuine history.

Function
REQ-011 SHALL, on each clk edge with en=1 and clr=0, write xin to mem[wptr] and advance wptr modulo DEPTH.
REQ-012 SHALL, in that same edge, register yout_q <= mem[(wptr - D) mod DEPTH] with read-before-write, so that after the edge of en-cycle k, yout = x(k-D).
REQ-013 SHALL support D=DEPTH by reading the old content of the location being overwritten.
REQ-014 SHALL keep fill_cnt counting accepted samples, saturating at DEPTH.
REQ-015 SHALL implement states IDLE (no samples), FILL (0<fill_cnt<DEPTH), RUN (fill_cnt=DEPTH); IDLE->FILL on first accepted sample, FILL->RUN when fill_cnt reaches DEPTH, any->IDLE on clr.
REQ-016 SHALL register valid_q <= (fill_cnt >= D) on every accepted sample, fill_cnt taken before the increment.
REQ-017 SHALL drive yout = en ? yout_q : 0 and yvalid = en ? valid_q : 0 combinationally.
REQ-018 SHALL hold wptr, fill_cnt, state, yout_q and valid_q unchanged while en=0.
REQ-019 SHALL, on clr=1, zero wptr, fill_cnt, yout_q and valid_q and enter IDLE; clr wins over simultaneous en and that sample is discarded; mem contents are not cleared.
REQ-020 SHALL accept a change of delay on any cycle with no restart; validity is re-evaluated per REQ-016 against current history.

Reset
REQ-021 SHALL, with rstn=0, asynchronously force wptr=0, fill_cnt=0, yout_q=0, valid_q=0 and state IDLE; yout=0 and yvalid=0.
REQ-022 SHALL not reset mem; stale contents are masked by fill_cnt.
REQ-023 SHALL, on reset mid-operation, discard all history, requiring D new samples before yvalid=1.

Configuration
REQ-024 SHALL, with TDR_DELAY_CLAMP_EN defined, clamp delay 0 to 1 and delay>DEPTH to DEPTH before use.
REQ-025 SHALL, without TDR_DELAY_CLAMP_EN, treat delay 0 or delay>DEPTH as invalid: valid_q <= 0 and yout_q <= 0 on that accepted sample, with write and pointer advance unaffected.

Structure
REQ-026 SHALL take the default DATA_WIDTH, default DEPTH and the state-encoding typedef (IDLE/FILL/RUN) from the shared pipeline package pt_pkg.
REQ-027 SHALL place storage in one sub-module tdr_ring_ram (one write port, one read-before-write registered read port); pointers, counter and FSM stay in tap_delay_reader.

Verification (DATA_WIDTH=16, DEPTH=8)
REQ-028 SHALL cover: D=3, en=1, xin=1,2,3,... -> yvalid first 1 after 4th edge with yout=1, then yout=2,3,... every cycle.
REQ-029 SHALL cover: D=8, 10 samples 10..19 -> yvalid 1 after 9th edge with yout=10, then yout=11 after the 10th edge.
REQ-030 SHALL cover: run at D=3, then en=0 for 5 cycles -> yout=0 and yvalid=0 during the gap; on the next en the sequence continues with no lost or repeated sample.
REQ-031 SHALL cover: clr asserted with en=1 after 6 samples -> sample dropped, state IDLE, yvalid=0 until 3 new samples are accepted.
REQ-032 SHALL cover: rstn pulsed low mid-RUN -> yout=0 and yvalid=0 immediately; D=2 refill yields first valid yout = 1st post-reset sample after the 3rd edge.
REQ-033 SHALL cover: delay=0 and delay=9 -> clamped to 1 and 8 with the macro; yvalid=0 and yout=0 without it.
